// File: rtl/arcade_input_ctrl.sv
// Arcade control front end: PS/2 + joystick decode, rotation,
// opposite-direction cleaning, coin pulses and frame-locked autofire.
module arcade_input_ctrl #(
  parameter int          PLAYERS         = 2,
  parameter logic [15:0] COIN_PULSE_CYC  = 16'd12000,
  parameter int          AUTOFIRE_FRAMES = 4,
  parameter bit          COIN_ON_START   = 1'b1
) (
  input  logic                    clk_sys,
  input  logic                    RESET_N,
  input  logic [64:0]             ps2_key,
  input  logic [16*PLAYERS-1:0]   joy_in,
  input  logic                    merge_joys,
  input  logic [1:0]              rotate,
  input  logic [PLAYERS-1:0]      autofire_en,
  input  logic                    ce_frame,
  output logic [4*PLAYERS-1:0]    dir_out,
  output logic [PLAYERS-1:0]      fire_out,
  output logic [PLAYERS-1:0]      start_out,
  output logic [PLAYERS-1:0]      coin_out
);

  localparam int AFW = $clog2(AUTOFIRE_FRAMES + 1);

  logic       r_old;
  logic [6:0] r_k0;
  logic [6:0] r_k1;
  logic       w_pressed;
  logic       w_ext;
  logic       w_evt;
  logic [8:0] w_code;

  assign w_pressed = ps2_key[15:8] != 8'hF0;
  assign w_ext     = w_pressed ? (ps2_key[15:8] == 8'hE0)
                               : (ps2_key[23:16] == 8'hE0);
  assign w_code    = (|ps2_key[63:24]) ? 9'd0 : {w_ext, ps2_key[7:0]};
  assign w_evt     = r_old != ps2_key[64];

  // key bits: 0 R, 1 L, 2 D, 3 U, 4 fire, 5 start, 6 coin
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_old <= 1'b0;
      r_k0  <= '0;
      r_k1  <= '0;
    end else begin
      r_old <= ps2_key[64];
      if (w_evt) begin
        case (w_code)
          9'h175:         r_k0[3] <= w_pressed;
          9'h172:         r_k0[2] <= w_pressed;
          9'h16B:         r_k0[1] <= w_pressed;
          9'h174:         r_k0[0] <= w_pressed;
          9'h029, 9'h014: r_k0[4] <= w_pressed;
          9'h005:         r_k0[5] <= w_pressed;
          9'h02E:         r_k0[6] <= w_pressed;
          9'h02D:         r_k1[3] <= w_pressed;
          9'h02B:         r_k1[2] <= w_pressed;
          9'h023:         r_k1[1] <= w_pressed;
          9'h034:         r_k1[0] <= w_pressed;
          9'h01C:         r_k1[4] <= w_pressed;
          9'h006:         r_k1[5] <= w_pressed;
          9'h036:         r_k1[6] <= w_pressed;
          default: ;
        endcase
      end
    end
  end

  logic [7:0] w_src [PLAYERS];
  logic [7:0] w_merge;
  logic [7:0] w_k0;
  logic [7:0] w_k1;
  logic [8*PLAYERS-1:0] w_unused_hi;

  assign w_k0 = {r_k0[6], 1'b0, r_k0[5:0]};
  assign w_k1 = {r_k1[6], 1'b0, r_k1[5:0]};

  // sources use the joystick bit layout, coin at bit 7
  always_comb begin
    w_merge = '0;
    for (int k = 0; k < PLAYERS; k++) w_merge |= joy_in[16*k +: 8];
    for (int k = 0; k < PLAYERS; k++) begin
      w_src[k] = merge_joys ? w_merge : joy_in[16*k +: 8];
      if (k == 0) w_src[k] |= w_k0;
      if (k == 1) w_src[k] |= w_k1 | {2'b00, joy_in[6], 5'b00000};
    end
  end

  function automatic logic [3:0] f_dir(input logic [3:0] d,
                                       input logic [1:0] r);
    logic [3:0] o;
    case (r)
      2'd0: o = d;
      2'd1: o = {d[1], d[0], d[2], d[3]};
      2'd2: o = {d[2], d[3], d[0], d[1]};
      2'd3: o = {d[0], d[1], d[3], d[2]};
    endcase
    if (o[3] & o[2]) o[3:2] = 2'b00;
    if (o[1] & o[0]) o[1:0] = 2'b00;
    return o;
  endfunction

  for (genvar k = 0; k < PLAYERS; k++) begin : g_pl
    logic [3:0]     r_dir;
    logic           r_start;
    logic           r_fire;
    logic           r_act;
    logic           r_prev;
    logic [15:0]    r_coin;
    logic [AFW-1:0] r_afc;
    logic           w_fire;
    logic           w_trig;

    assign w_unused_hi[8*k +: 8] = joy_in[16*k+8 +: 8];
    assign w_fire = w_src[k][4];
    assign w_trig = w_src[k][7] | (COIN_ON_START & w_src[k][5]);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
        r_dir   <= '0;
        r_start <= 1'b0;
        r_prev  <= 1'b0;
        r_coin  <= '0;
      end else begin
        r_dir   <= f_dir(w_src[k][3:0], rotate);
        r_start <= w_src[k][5];
        r_prev  <= w_trig;
        if (r_coin != 16'd0)
          r_coin <= r_coin - 16'd1;
        else if (w_trig & ~r_prev)
          r_coin <= COIN_PULSE_CYC;
      end
    end

    // r_act marks a press already in autofire; its absence restarts phase 1
    always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
        r_fire <= 1'b0;
        r_act  <= 1'b0;
        r_afc  <= '0;
      end else begin
        r_act <= autofire_en[k] & w_fire;
        if (!autofire_en[k]) begin
          r_fire <= w_fire;
          r_afc  <= '0;
        end else if (!w_fire) begin
          r_fire <= 1'b0;
          r_afc  <= '0;
        end else if (!r_act) begin
          r_fire <= 1'b1;
          r_afc  <= '0;
        end else if (ce_frame) begin
          if (r_afc == AFW'(AUTOFIRE_FRAMES - 1)) begin
            r_fire <= ~r_fire;
            r_afc  <= '0;
          end else begin
            r_afc <= r_afc + 1'b1;
          end
        end
      end
    end

    assign dir_out[4*k +: 4] = r_dir;
    assign fire_out[k]       = r_fire;
    assign start_out[k]      = r_start;
    assign coin_out[k]       = r_coin != 16'd0;
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: directed cases plus random stimulus
// checked every cycle against a behavioural model.
module tb_arcade_input_ctrl;

  localparam int P  = 2;
  localparam int NC = 5;
  localparam int AF = 2;

  logic        clk_sys     = 1'b0;
  logic        RESET_N     = 1'b0;
  logic [64:0] ps2_key     = '0;
  logic [31:0] joy_in      = '0;
  logic        merge_joys  = 1'b0;
  logic [1:0]  rotate      = 2'd0;
  logic [1:0]  autofire_en = 2'b00;
  logic        ce_frame    = 1'b0;
  logic [7:0]  dir_out;
  logic [1:0]  fire_out;
  logic [1:0]  start_out;
  logic [1:0]  coin_out;

  arcade_input_ctrl #(
    .PLAYERS(P), .COIN_PULSE_CYC(16'd5),
    .AUTOFIRE_FRAMES(AF), .COIN_ON_START(1'b1)
  ) dut (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .ps2_key(ps2_key),
    .joy_in(joy_in), .merge_joys(merge_joys), .rotate(rotate),
    .autofire_en(autofire_en), .ce_frame(ce_frame),
    .dir_out(dir_out), .fire_out(fire_out),
    .start_out(start_out), .coin_out(coin_out)
  );

  always #5 clk_sys = ~clk_sys;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 0;

  task automatic chk(input string nm, input int p,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s p%0d: got %0h expected %0h at %0t",
                  nm, p, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // key state per player in joystick bit layout (coin at bit 7)
  logic [15:0] kst;
  bit          m_old;
  longint      cyc;
  longint      c_start [2];
  longint      c_end   [2];
  bit          m_prev  [2];
  bit          m_act   [2];
  int          m_frm   [2];
  logic [3:0]  e_dir   [2];
  logic        e_fire  [2];
  logic        e_start [2];

  // RT[r][out] = raw bit feeding output bit (0 R, 1 L, 2 D, 3 U)
  int RT [4][4] = '{'{0, 1, 2, 3}, '{3, 2, 0, 1},
                    '{1, 0, 3, 2}, '{2, 3, 1, 0}};

  function automatic int keyfn(input logic [8:0] c);
    case (c)
      9'h175: return 3;       9'h172: return 2;
      9'h16B: return 1;       9'h174: return 0;
      9'h029: return 4;       9'h014: return 4;
      9'h005: return 5;       9'h02E: return 7;
      9'h02D: return 11;      9'h02B: return 10;
      9'h023: return 9;       9'h034: return 8;
      9'h01C: return 12;      9'h006: return 13;
      9'h036: return 15;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] src(input int k);
    logic [7:0] s;
    s = merge_joys ? (joy_in[7:0] | joy_in[23:16]) : joy_in[16*k +: 8];
    s |= kst[8*k +: 8];
    if (k == 1) s[5] |= joy_in[6];
    return s;
  endfunction

  function automatic logic [3:0] dirx(input logic [3:0] d,
                                      input logic [1:0] r);
    logic [3:0] o;
    for (int b = 0; b < 4; b++) o[b] = d[RT[r][b]];
    if (o[3] && o[2]) o[3:2] = 2'b00;
    if (o[1] && o[0]) o[1:0] = 2'b00;
    return o;
  endfunction

  function automatic logic e_coin(input int k);
    return (cyc >= c_start[k]) && (cyc <= c_end[k]);
  endfunction

  always @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      kst = '0; m_old = 0;
      for (int k = 0; k < 2; k++) begin
        c_start[k] = 1; c_end[k] = 0; m_prev[k] = 0;
        m_act[k] = 0; m_frm[k] = 0;
        e_dir[k] = '0; e_fire[k] = 0; e_start[k] = 0;
      end
    end else begin
      logic [7:0] s;
      logic       t, busy, pr, ex;
      logic [8:0] code;
      int         fn;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        s = src(k);
        e_dir[k]   = dirx(s[3:0], rotate);
        e_start[k] = s[5];
        if (!autofire_en[k]) e_fire[k] = s[4];
        else if (!s[4]) e_fire[k] = 0;
        else if (!m_act[k]) begin
          m_frm[k] = 0; e_fire[k] = 1;
        end else if (ce_frame) begin
          m_frm[k]++;
          e_fire[k] = ((m_frm[k] / AF) % 2) == 0;
        end
        m_act[k] = autofire_en[k] & s[4];
        t    = s[7] | s[5];
        busy = (cyc - 1 >= c_start[k]) && (cyc - 1 <= c_end[k]);
        if (t && !m_prev[k] && !busy) begin
          c_start[k] = cyc; c_end[k] = cyc + NC - 1;
        end
        m_prev[k] = t;
      end
      if (ps2_key[64] != m_old) begin
        pr   = ps2_key[15:8] != 8'hF0;
        ex   = pr ? ps2_key[15:8] == 8'hE0 : ps2_key[23:16] == 8'hE0;
        code = (ps2_key[63:24] != 0) ? 9'd0 : {ex, ps2_key[7:0]};
        fn   = keyfn(code);
        if (fn >= 0) kst[fn] = pr;
      end
      m_old = ps2_key[64];
    end
  end

  always @(negedge clk_sys) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("dir",   k, 32'(dir_out[4*k +: 4]), 32'(e_dir[k]));
        chk("fire",  k, 32'(fire_out[k]),  32'(e_fire[k]));
        chk("start", k, 32'(start_out[k]), 32'(e_start[k]));
        chk("coin",  k, 32'(coin_out[k]),  32'(e_coin(k)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic ps2_ev(input logic [8:0] c, input bit press,
                        input bit junk);
    logic [64:0] b;
    b = '0;
    b[7:0] = c[7:0];
    if (press) b[15:8] = c[8] ? 8'hE0 : 8'h00;
    else begin
      b[15:8]  = 8'hF0;
      b[23:16] = c[8] ? 8'hE0 : 8'h00;
    end
    if (junk) b[40] = 1'b1;
    b[64] = ~ps2_key[64];
    ps2_key = b;
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  logic [8:0] keys [15] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029,
                            9'h014, 9'h005, 9'h02E, 9'h02D, 9'h02B,
                            9'h023, 9'h034, 9'h01C, 9'h006, 9'h036};

  initial begin
    int n_c0, n_c1, n_st, n_f, first_c, nz;
    cyc = 0;
    @(posedge clk_sys);
    chk_on = 1;
    @(negedge clk_sys);
    chk("rst_dir", 0, 32'(dir_out), 0);
    chk("rst_out", 0, 32'({fire_out, start_out, coin_out}), 0);
    cyc_n(2);
    RESET_N = 1;
    cyc_n(2);

    // plain direction and 90 degree rotation
    joy_in[3:0] = 4'b1000;
    cyc_n(1);
    chk("joy_up", 0, 32'(dir_out[3:0]), 32'h8);
    rotate = 2'd1; joy_in[3:0] = 4'b0010;
    cyc_n(1);
    chk("rot90_L", 0, 32'(dir_out[3:0]), 32'h8);

    // opposite-direction cleaning
    rotate = 2'd0; joy_in[3:0] = 4'b1110;
    cyc_n(1);
    chk("clean_r0", 0, 32'(dir_out[3:0]), 32'h2);
    rotate = 2'd2;
    cyc_n(1);
    chk("clean_r2", 0, 32'(dir_out[3:0]), 32'h1);
    rotate = 2'd0; joy_in = '0;
    cyc_n(2);

    // PS/2 extended up key: press, release, junk event
    ps2_ev(9'h175, 1, 0);
    cyc_n(1);
    chk("ps2_lat1", 0, 32'(dir_out[3]), 0);
    cyc_n(1);
    chk("ps2_press", 0, 32'(dir_out[3]), 1);
    ps2_ev(9'h175, 0, 0);
    cyc_n(2);
    chk("ps2_rel", 0, 32'(dir_out[3]), 0);
    ps2_ev(9'h175, 1, 1);
    cyc_n(2);
    chk("ps2_junk", 0, 32'(dir_out[3]), 0);

    // coin pulse from start key; second edge mid-pulse on player 1
    n_c0 = 0; n_c1 = 0; n_st = 0; first_c = -1;
    ps2_ev(9'h005, 1, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_sys);
      if (coin_out[0]) begin
        n_c0++;
        if (first_c < 0) first_c = i;
      end
      n_c1 += int'(coin_out[1]);
      n_st += int'(start_out[0]);
      if (i == 19) ps2_ev(9'h005, 0, 0);
      if (i == 2) joy_in[23] = 1'b1;
      if (i == 3) joy_in[23] = 1'b0;
      if (i == 5) joy_in[23] = 1'b1;
      if (i == 8) joy_in[23] = 1'b0;
    end
    chk("coin_len", 0, 32'(n_c0), 5);
    chk("coin_first", 0, 32'(first_c), 1);
    chk("start_len", 0, 32'(n_st), 20);
    chk("coin_noext", 1, 32'(n_c1), 5);

    // autofire on player 1, strobe every 10 clocks
    n_f = 0;
    autofire_en = 2'b10; joy_in[20] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_sys);
      if (i == 0) chk("af_first", 1, 32'(fire_out[1]), 1);
      n_f += int'(fire_out[1]);
      ce_frame = (i % 10) == 9;
    end
    ce_frame = 1'b0;
    chk("af_high", 1, 32'(n_f), 40);
    joy_in[20] = 1'b0;
    cyc_n(1);
    chk("af_rel", 1, 32'(fire_out[1]), 0);
    autofire_en = 2'b00;
    cyc_n(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      for (int b = 0; b < 32; b++)
        if ((b % 16) < 8 && $urandom_range(0, 23) == 0)
          joy_in[b] = ~joy_in[b];
      if ($urandom_range(0, 49) == 0) rotate = 2'($urandom);
      if ($urandom_range(0, 79) == 0) merge_joys = ~merge_joys;
      if ($urandom_range(0, 59) == 0)
        autofire_en = autofire_en ^ 2'($urandom_range(1, 2));
      ce_frame = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 5) == 0) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 15)
          ps2_ev(keys[r], 1'($urandom), $urandom_range(0, 9) == 0);
        else
          ps2_ev(9'($urandom), 1'($urandom), 0);
      end
    end

    // reset in the middle of a coin pulse and a held press
    joy_in = 32'h0000_0090; merge_joys = 0; rotate = 0;
    autofire_en = 0; ce_frame = 0; ps2_key = '0;
    cyc_n(3);
    #2 RESET_N = 0;
    #1;
    chk("rst_mid_dir", 0, 32'(dir_out), 0);
    chk("rst_mid_out", 0, 32'({fire_out, start_out, coin_out}), 0);
    joy_in = '0;
    cyc_n(2);
    RESET_N = 1;
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if ({dir_out, fire_out, start_out, coin_out} != 0) nz++;
    end
    chk("rst_idle", 0, 32'(nz), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
